// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset causes and counter sizing.
package rst_seq_pkg;

  typedef enum logic [1:0] {S_HOLD, S_REL, S_RUN} rst_seq_state_e;

  typedef enum logic [1:0] {CAUSE_POR, CAUSE_SW, CAUSE_DBG, CAUSE_WDT} rst_cause_e;

  // Wide enough to reach the larger of the two terminal counts without wrapping.
  function automatic int rst_seq_cnt_width(input int hold_cycles, input int stagger_cycles);
    int max_cycles;
    max_cycles = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds periph/core resets, releases periph then core, re-asserts on requests.
// Optional RST_SEQ_CAUSE_EN adds the registered rst_cause_o output.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       sw_rst_req_i,
  input  logic       dbg_rst_req_i,
  input  logic       wdt_rst_req_i,
  output logic       periph_rst_no,
  output logic       core_rst_no,
  output logic       rst_busy_o
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0] rst_cause_o
`endif
);

  localparam int CW = rst_seq_cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);

  rst_seq_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           periph_q, periph_d;
  logic           core_q, core_d;
  logic           req;

  assign req = sw_rst_req_i | wdt_rst_req_i | dbg_rst_req_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    if (req) begin
      // Any request, in any state, restarts the whole sequence from the top of HOLD.
      state_d  = S_HOLD;
      cnt_d    = '0;
      periph_d = 1'b0;
      core_d   = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d    = '0;
            periph_d = 1'b1;
            if (STAGGER_CYCLES == 0) begin
              state_d = S_RUN;
              core_d  = 1'b1;
            end else begin
              state_d = S_REL;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_REL: begin
          if (cnt_q == STAG_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            core_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          periph_d = 1'b0;
          core_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
    end
  end

  assign periph_rst_no = periph_q;
  assign core_rst_no   = core_q;
  assign rst_busy_o    = (state_q != S_RUN);

`ifdef RST_SEQ_CAUSE_EN
  rst_cause_e cause_q, cause_d;

  // Simultaneous requests record the highest-priority source: WDT > DBG > SW.
  always_comb begin
    cause_d = cause_q;
    if (wdt_rst_req_i) begin
      cause_d = CAUSE_WDT;
    end else if (dbg_rst_req_i) begin
      cause_d = CAUSE_DBG;
    end else if (sw_rst_req_i) begin
      cause_d = CAUSE_SW;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q <= CAUSE_POR;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;
`else
  // Without cause tracking the request sources only feed the sequencing logic.
`endif

endmodule
